bank_cmd_timer: RTL and testbench

BANK_CMD_TIMER -- requirements
Module: bank_cmd_timer

---
 rtl/bank_cmd_timer_pkg.sv | 59 +++++
 rtl/bank_cmd_timer_if.sv | 30 +++
 rtl/bank_cmd_timer_timing_down_counter.sv | 27 ++
 rtl/bank_cmd_timer.sv | 118 +++++++++++
 tb/tb_bank_cmd_timer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/bank_cmd_timer_pkg.sv
// Shared types for the per-bank command timer: bank FSM states,
// DRAM command codes, row tracker states and default timing values.
package bank_cmd_timer_pkg;

    localparam int FSM_WIDTH2 = 4;
    localparam int ADDR_BITS  = 14;

    localparam int T_RCD_DEF  = 4;
    localparam int T_RP_DEF   = 4;
    localparam int T_RAS_DEF  = 10;
    localparam int T_WR_DEF   = 5;
    localparam int T_RTP_DEF  = 3;
    localparam int T_CCD_DEF  = 2;
    localparam int CNT_W_DEF  = 5;

    typedef enum logic [FSM_WIDTH2-1:0] {
        B_IDLE          = 4'd0,
        B_ACTIVE        = 4'd1,
        B_OPEN          = 4'd2,
        B_READ          = 4'd3,
        B_WRITE         = 4'd4,
        B_PRE           = 4'd5,
        B_ISSUE_REFRESH = 4'd6,
        B_REFRESH       = 4'd7
    } bank_state_t;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } dram_cmd_t;

    typedef enum logic {
        ROW_CLOSED = 1'b0,
        ROW_OPEN   = 1'b1
    } row_state_t;

    // Command implied by the bank FSM state; NOP unless it asks to issue.
    function automatic dram_cmd_t decode_cmd(input bank_state_t st,
                                             input logic issue);
        dram_cmd_t c;
        c = CMD_NOP;
        if (issue) begin
            case (st)
                B_ACTIVE:        c = CMD_ACT;
                B_READ:          c = CMD_RD;
                B_WRITE:         c = CMD_WR;
                B_PRE:           c = CMD_PRE;
                B_ISSUE_REFRESH: c = CMD_REF;
                default:         c = CMD_NOP;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/bank_cmd_timer_if.sv
// Bank FSM / channel arbiter bundle around the command timer.
// master: bank FSM + arbiter side; slave: the timer itself.
interface bank_cmd_timer_if;
    import bank_cmd_timer_pkg::*;

    bank_state_t          ba_state;
    logic                 ba_issue;
    logic [ADDR_BITS-1:0] ba_addr;
    logic [2:0]           number;
    logic                 cmd_ready;
    logic                 stall;
    logic                 cmd_valid;
    dram_cmd_t            cmd_type;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [2:0]           cmd_bank;
    logic                 protocol_err;

    modport master (
        output ba_state, ba_issue, ba_addr, number, cmd_ready,
        input  stall, cmd_valid, cmd_type, cmd_addr, cmd_bank,
        input  protocol_err
    );

    modport slave (
        input  ba_state, ba_issue, ba_addr, number, cmd_ready,
        output stall, cmd_valid, cmd_type, cmd_addr, cmd_bank,
        output protocol_err
    );

endinterface

// File: rtl/bank_cmd_timer_timing_down_counter.sv
// Loadable down counter that saturates at zero.
// Ports: clk, rst (async high), load, load_val -> zero (count is 0).
module timing_down_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/bank_cmd_timer.sv
// Per-bank DRAM command timer: gates bank FSM commands on row state
// and timing counters. Ports: clk, rst (async high), bus (slave).
module bank_cmd_timer
    import bank_cmd_timer_pkg::*;
#(
    parameter int TRCD  = T_RCD_DEF,
    parameter int TRP   = T_RP_DEF,
    parameter int TRAS  = T_RAS_DEF,
    parameter int TWR   = T_WR_DEF,
    parameter int TRTP  = T_RTP_DEF,
    parameter int TCCD  = T_CCD_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    bank_cmd_timer_if.slave bus
);

    dram_cmd_t  cmd;
    row_state_t row;
    logic       err_q;

    logic is_act, is_rd, is_wr, is_pre, is_ref;
    logic legal, illegal, t_ready, valid, accept;
    logic trcd_z, trp_z, tras_z, twr_z, trtp_z, tccd_z;

    assign cmd    = decode_cmd(bus.ba_state, bus.ba_issue);
    assign is_act = (cmd == CMD_ACT);
    assign is_rd  = (cmd == CMD_RD);
    assign is_wr  = (cmd == CMD_WR);
    assign is_pre = (cmd == CMD_PRE);
    assign is_ref = (cmd == CMD_REF);

    // legal already implies ba_issue and a non-NOP command
    assign legal =
        ((is_act | is_ref) & (row == ROW_CLOSED)) |
        ((is_rd | is_wr | is_pre) & (row == ROW_OPEN));
    assign illegal = (cmd != CMD_NOP) & ~legal;

    always_comb begin
        t_ready = 1'b0;
        case (cmd)
            CMD_ACT, CMD_REF: t_ready = trp_z;
            CMD_RD, CMD_WR:   t_ready = trcd_z & tccd_z;
            CMD_PRE:          t_ready = tras_z & twr_z & trtp_z;
            default:          t_ready = 1'b0;
        endcase
    end

    assign valid  = legal & t_ready & ~rst;
    assign accept = valid & bus.cmd_ready;

    assign bus.cmd_valid    = valid;
    assign bus.stall        = legal & ~(t_ready & bus.cmd_ready) & ~rst;
    assign bus.cmd_type     = rst ? CMD_NOP : cmd;
    assign bus.cmd_addr     = bus.ba_addr;
    assign bus.cmd_bank     = bus.number;
    assign bus.protocol_err = err_q;

    // Row tracker and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row   <= ROW_CLOSED;
            err_q <= 1'b0;
        end else begin
            case (row)
                ROW_CLOSED: if (accept & is_act) row <= ROW_OPEN;
                ROW_OPEN:   if (accept & is_pre) row <= ROW_CLOSED;
                default:    row <= ROW_CLOSED;
            endcase
            if (illegal) err_q <= 1'b1;
        end
    end

    // Loading param-1 means the gated command can go param cycles later
    timing_down_counter #(.W(CNT_W)) u_trcd (
        .clk(clk), .rst(rst),
        .load(accept & is_act),
        .load_val(CNT_W'(TRCD - 1)),
        .zero(trcd_z)
    );

    timing_down_counter #(.W(CNT_W)) u_trp (
        .clk(clk), .rst(rst),
        .load(accept & (is_pre | is_ref)),
        .load_val(CNT_W'(TRP - 1)),
        .zero(trp_z)
    );

    timing_down_counter #(.W(CNT_W)) u_tras (
        .clk(clk), .rst(rst),
        .load(accept & is_act),
        .load_val(CNT_W'(TRAS - 1)),
        .zero(tras_z)
    );

    timing_down_counter #(.W(CNT_W)) u_twr (
        .clk(clk), .rst(rst),
        .load(accept & is_wr),
        .load_val(CNT_W'(TWR - 1)),
        .zero(twr_z)
    );

    timing_down_counter #(.W(CNT_W)) u_trtp (
        .clk(clk), .rst(rst),
        .load(accept & is_rd),
        .load_val(CNT_W'(TRTP - 1)),
        .zero(trtp_z)
    );

    timing_down_counter #(.W(CNT_W)) u_tccd (
        .clk(clk), .rst(rst),
        .load(accept & (is_rd | is_wr)),
        .load_val(CNT_W'(TCCD - 1)),
        .zero(tccd_z)
    );

endmodule

// File: tb/tb_bank_cmd_timer.sv
// Scoreboard bench for bank_cmd_timer: per-cycle expectations are
// queued at drive time and compared on the falling edge.
module tb_bank_cmd_timer;
    import bank_cmd_timer_pkg::*;

    typedef struct {
        string                tag;
        logic                 stall;
        logic                 valid;
        dram_cmd_t            typ;
        logic                 err;
        logic [ADDR_BITS-1:0] addr;
        logic [2:0]           bank;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];
    exp_t mon_e;

    bank_cmd_timer_if bus();

    bank_cmd_timer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk({mon_e.tag, ".stall"}, 32'(bus.stall), 32'(mon_e.stall));
            chk({mon_e.tag, ".valid"}, 32'(bus.cmd_valid), 32'(mon_e.valid));
            chk({mon_e.tag, ".type"}, 32'(bus.cmd_type), 32'(mon_e.typ));
            chk({mon_e.tag, ".err"}, 32'(bus.protocol_err), 32'(mon_e.err));
            chk({mon_e.tag, ".addr"}, 32'(bus.cmd_addr), 32'(mon_e.addr));
            chk({mon_e.tag, ".bank"}, 32'(bus.cmd_bank), 32'(mon_e.bank));
        end
    end

    task automatic drive_push(input string tag, input bank_state_t st,
                              input logic iss, input logic rdy,
                              input logic es, input logic ev,
                              input dram_cmd_t et, input logic ee);
        exp_t e;
        bus.ba_state  = st;
        bus.ba_issue  = iss;
        bus.cmd_ready = rdy;
        bus.ba_addr   = ADDR_BITS'($urandom);
        bus.number    = 3'($urandom);
        e.tag   = tag;
        e.stall = es;
        e.valid = ev;
        e.typ   = et;
        e.err   = ee;
        e.addr  = bus.ba_addr;
        e.bank  = bus.number;
        sb.push_back(e);
    endtask

    task automatic step(input string tag, input bank_state_t st,
                        input logic iss, input logic rdy,
                        input logic es, input logic ev,
                        input dram_cmd_t et, input logic ee);
        drive_push(tag, st, iss, rdy, es, ev, et, ee);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic ee);
        step(tag, B_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, CMD_NOP, ee);
    endtask

    initial begin
        bus.ba_state  = B_IDLE;
        bus.ba_issue  = 1'b0;
        bus.ba_addr   = '0;
        bus.number    = '0;
        bus.cmd_ready = 1'b0;
        @(posedge clk);
        #1;

        // reset holds everything quiet even with a ready ACT
        step("rst_act", B_ACTIVE, 1, 1, 0, 0, CMD_NOP, 0);
        step("rst_rd", B_READ, 1, 1, 0, 0, CMD_NOP, 0);
        rst = 1'b0;

        // ACT then RD: tRCD stall, RD at cycle 4
        step("c0_act", B_ACTIVE, 1, 1, 0, 1, CMD_ACT, 0);
        for (int i = 1; i <= 3; i++)
            step("trcd_wait", B_READ, 1, 1, 1, 0, CMD_RD, 0);
        step("c4_rd", B_READ, 1, 1, 0, 1, CMD_RD, 0);
        idle("c5_idle", 0);
        idle("c6_idle", 0);

        // ready RD held off by arbiter for 3 cycles
        for (int i = 7; i <= 9; i++)
            step("no_grant", B_READ, 1, 0, 1, 1, CMD_RD, 0);
        step("c10_rd", B_READ, 1, 1, 0, 1, CMD_RD, 0);
        step("c11_tccd", B_READ, 1, 1, 1, 0, CMD_RD, 0);
        step("c12_rd", B_READ, 1, 1, 0, 1, CMD_RD, 0);

        // PRE after RD waits on tRTP
        step("trtp_wait", B_PRE, 1, 1, 1, 0, CMD_PRE, 0);
        step("trtp_wait", B_PRE, 1, 1, 1, 0, CMD_PRE, 0);
        step("c15_pre", B_PRE, 1, 1, 0, 1, CMD_PRE, 0);

        // REF after PRE waits on tRP
        for (int i = 16; i <= 18; i++)
            step("trp_wait", B_ISSUE_REFRESH, 1, 1, 1, 0, CMD_REF, 0);
        step("c19_ref", B_ISSUE_REFRESH, 1, 1, 0, 1, CMD_REF, 0);

        // RD with row closed is dropped and flags an error
        step("c20_bad_rd", B_READ, 1, 1, 0, 0, CMD_RD, 0);
        step("c21_act", B_ACTIVE, 1, 1, 1, 0, CMD_ACT, 1);
        step("c22_act", B_ACTIVE, 1, 1, 1, 0, CMD_ACT, 1);
        step("c23_act", B_ACTIVE, 1, 1, 0, 1, CMD_ACT, 1);
        for (int i = 24; i <= 26; i++)
            step("trcd_wait2", B_READ, 1, 1, 1, 0, CMD_RD, 1);
        step("c27_rd", B_READ, 1, 1, 0, 1, CMD_RD, 1);

        // fresh start: ACT, abandoned RD, WR, PRE bound by tRAS
        rst = 1'b1;
        idle("rst2", 0);
        rst = 1'b0;
        step("d0_act", B_ACTIVE, 1, 1, 0, 1, CMD_ACT, 0);
        step("d1_abandon", B_READ, 1, 1, 1, 0, CMD_RD, 0);
        idle("d2_idle", 0);
        idle("d3_idle", 0);
        step("d4_wr", B_WRITE, 1, 1, 0, 1, CMD_WR, 0);
        for (int i = 5; i <= 9; i++)
            step("tras_wait", B_PRE, 1, 1, 1, 0, CMD_PRE, 0);
        step("d10_pre", B_PRE, 1, 1, 0, 1, CMD_PRE, 0);

        // reset mid-wait with error set and trcd pending
        rst = 1'b1;
        idle("rst3", 0);
        rst = 1'b0;
        step("e0_bad_rd", B_READ, 1, 1, 0, 0, CMD_RD, 0);
        step("e1_act", B_ACTIVE, 1, 1, 0, 1, CMD_ACT, 1);
        step("e2_wait", B_READ, 1, 1, 1, 0, CMD_RD, 1);
        drive_push("e3_wait", B_READ, 1, 1, 1, 0, CMD_RD, 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_stall", 32'(bus.stall), 32'd0);
        chk("async_valid", 32'(bus.cmd_valid), 32'd0);
        chk("async_type", 32'(bus.cmd_type), 32'(CMD_NOP));
        chk("async_err", 32'(bus.protocol_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_act", B_ACTIVE, 1, 1, 0, 1, CMD_ACT, 0);
        step("post_rd", B_READ, 1, 1, 1, 0, CMD_RD, 0);

        @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
